// File: rtl/fsk_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the FSK link (modulator and demodulator).
//   - fsk_state_e       : transmit sequencer states
//   - *_DEF constants   : default tone timing and framing
//   - RX_* constants    : receiver decision values derived from the tone timing,
//                         so both ends of the link stay consistent
//   - even_parity()     : even parity over one data byte
// Optional feature macro: FSK_PARITY_EN (adds a parity bit after the data bits).
// -----------------------------------------------------------------------------
package fsk_pkg;

    // Tone timing and framing defaults
    localparam int HALF0_DEF          = 100;
    localparam int HALF1_DEF          = 147;
    localparam int CYCLES_PER_BIT_DEF = 8;
    localparam int PREAMBLE_BITS_DEF  = 4;
    localparam int CNT_W_DEF          = 16;
    localparam int DATA_BITS          = 8;

    // The receiver counts HALF-1 clocks between carrier edges and decides on
    // the sum of two consecutive intervals.
    localparam int RX_EDGE0    = HALF0_DEF - 1;
    localparam int RX_EDGE1    = HALF1_DEF - 1;
    localparam int RX_SUM0     = 2 * RX_EDGE0;
    localparam int RX_SUM1     = 2 * RX_EDGE1;
    localparam int RX_SUM1_LO  = RX_SUM1 - 8;
    localparam int RX_SUM1_HI  = RX_SUM1 + 8;
    localparam int RX_SUM_MID  = (RX_SUM0 + RX_SUM1) / 2;

    // Transmit sequencer states; ST_PARITY is only reachable with FSK_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5
    } fsk_state_e;

    // Even parity: 1 when the byte holds an odd number of ones
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// -----------------------------------------------------------------------------
// fsk_tone_gen
// Phase-continuous square-wave carrier for one FSK symbol at a time.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-low
//   run      in   carrier enabled for the coming cycle; rising run starts the
//                 carrier high, falling run forces the line low
//   sym      in   symbol selecting the half-period (0 -> HALF0, 1 -> HALF1)
//   fsk_out  out  registered carrier
//   bit_done out  combinational pulse on the cycle whose edge ends the
//                 current bit (last half-period of the bit expires)
// -----------------------------------------------------------------------------
module fsk_tone_gen
    import fsk_pkg::*;
#(
    parameter int HALF0          = HALF0_DEF,
    parameter int HALF1          = HALF1_DEF,
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sym,
    output logic fsk_out,
    output logic bit_done
);

    localparam int IDX_W = (2 * CYCLES_PER_BIT > 1) ? $clog2(2 * CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LIM0     = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] LIM1     = CNT_W'(HALF1 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] r_half_cnt;
    logic [IDX_W-1:0] r_half_idx;
    logic             r_on;
    logic             r_fsk_out;

    logic [CNT_W-1:0] w_limit;
    logic             w_half_end;

    // Half-period limit for the symbol currently being sent
    always_comb begin
        w_limit = LIM0;
        if (sym) begin
            w_limit = LIM1;
        end else begin
            w_limit = LIM0;
        end
    end

    assign w_half_end = r_on && (r_half_cnt == w_limit);
    assign bit_done   = w_half_end && (r_half_idx == IDX_LAST);
    assign fsk_out    = r_fsk_out;

    // Carrier state: the last half of every bit is low, so toggling at the
    // bit end always goes high and the next bit starts high with no phase jump
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_on       <= 1'b0;
            r_fsk_out  <= 1'b0;
            r_half_cnt <= '0;
            r_half_idx <= '0;
        end else if (!run) begin
            r_on       <= 1'b0;
            r_fsk_out  <= 1'b0;
            r_half_cnt <= '0;
            r_half_idx <= '0;
        end else if (!r_on) begin
            r_on       <= 1'b1;
            r_fsk_out  <= 1'b1;
            r_half_cnt <= '0;
            r_half_idx <= '0;
        end else if (w_half_end) begin
            r_fsk_out  <= ~r_fsk_out;
            r_half_cnt <= '0;
            if (r_half_idx == IDX_LAST) begin
                r_half_idx <= '0;
            end else begin
                r_half_idx <= r_half_idx + IDX_W'(1);
            end
        end else begin
            r_half_cnt <= r_half_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsk_modulator.sv
// -----------------------------------------------------------------------------
// fsk_modulator
// Byte-serial FSK transmitter. Each accepted byte is framed as
//   preamble (PREAMBLE_BITS x symbol 1), start (0), 8 data bits LSB first,
//   [even parity], stop (1)
// and sent as a phase-continuous square-wave carrier. The line is held low
// while idle.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-low
//   in_data  in   byte to transmit, sampled on the accept edge only
//   in_valid in   in_data valid
//   in_ready out  block can accept a byte (registered)
//   fsk_out  out  FSK carrier (registered)
//   busy     out  frame in progress (registered)
//   sym_out  out  symbol currently being sent (registered, debug)
// Optional feature macro: FSK_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit.
// -----------------------------------------------------------------------------
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int HALF0          = HALF0_DEF,
    parameter int HALF1          = HALF1_DEF,
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEF,
    parameter int PREAMBLE_BITS  = PREAMBLE_BITS_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       fsk_out,
    output logic       busy,
    output logic       sym_out
);

    localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

    fsk_state_e r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_in_ready;
    logic       r_busy;
    logic       r_sym;

    fsk_state_e w_state;
    logic [7:0] w_shift;
    logic [3:0] w_bit_cnt;
    logic       w_in_ready;
    logic       w_busy;
    logic       w_sym;
    logic       w_run;
    logic       w_bit_done;
    logic       w_fsk_out;

`ifdef FSK_PARITY_EN
    logic       r_parity;
    logic       w_parity;
`endif

    fsk_tone_gen #(
        .HALF0          (HALF0),
        .HALF1          (HALF1),
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .CNT_W          (CNT_W)
    ) u_tone (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (w_run),
        .sym      (r_sym),
        .fsk_out  (w_fsk_out),
        .bit_done (w_bit_done)
    );

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign sym_out  = r_sym;
    assign fsk_out  = w_fsk_out;

    // Sequencer next state; every symbol change lands on the edge that ends
    // the previous bit so the tone generator picks up the new half-period at once
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_in_ready = r_in_ready;
        w_busy     = r_busy;
        w_sym      = r_sym;
`ifdef FSK_PARITY_EN
        w_parity   = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                w_sym      = 1'b0;
                // r_in_ready gates acceptance, so the first edge after reset only raises ready
                if (in_valid && r_in_ready) begin
                    w_shift    = in_data;
                    w_bit_cnt  = 4'd0;
                    w_in_ready = 1'b0;
                    w_busy     = 1'b1;
                    w_sym      = 1'b1;
                    w_state    = ST_PREAMBLE;
`ifdef FSK_PARITY_EN
                    w_parity   = even_parity(in_data);
`endif
                end else begin
                    w_state    = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == PRE_LAST) begin
                        w_bit_cnt = 4'd0;
                        w_sym     = 1'b0;
                        w_state   = ST_START;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_state = ST_PREAMBLE;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_bit_cnt = 4'd0;
                    w_sym     = r_shift[0];
                    w_state   = ST_DATA;
                end else begin
                    w_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_cnt = 4'd0;
`ifdef FSK_PARITY_EN
                        w_sym     = r_parity;
                        w_state   = ST_PARITY;
`else
                        w_sym     = 1'b1;
                        w_state   = ST_STOP;
`endif
                    end else begin
                        // r_shift[1] becomes bit 0 on this same edge
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        w_sym     = r_shift[1];
                    end
                end else begin
                    w_state = ST_DATA;
                end
            end
`ifdef FSK_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_sym   = 1'b1;
                    w_state = ST_STOP;
                end else begin
                    w_state = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                // Frame end: the carrier is released instead of toggling high
                if (w_bit_done) begin
                    w_in_ready = 1'b1;
                    w_busy     = 1'b0;
                    w_sym      = 1'b0;
                    w_state    = ST_IDLE;
                end else begin
                    w_state = ST_STOP;
                end
            end
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
                w_sym      = 1'b0;
                w_bit_cnt  = 4'd0;
                w_state    = ST_IDLE;
            end
        endcase
        // Carrier runs in the cycle after this edge whenever a frame is active
        w_run = (w_state != ST_IDLE);
    end

    // Sequencer registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 4'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_sym      <= 1'b0;
`ifdef FSK_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_in_ready <= w_in_ready;
            r_busy     <= w_busy;
            r_sym      <= w_sym;
`ifdef FSK_PARITY_EN
            r_parity   <= w_parity;
`endif
        end
    end

endmodule

// File: tb/tb_fsk_modulator.sv
// -----------------------------------------------------------------------------
// tb_fsk_modulator
// Scoreboard bench for fsk_modulator. Accepted bytes are queued; a monitor
// measures every carrier run length and sym_out while busy and checks them
// against the frame expanded from the byte (symbol list -> half-periods).
// CYCLES_PER_BIT is reduced to 2 to keep frames short; HALF0/HALF1 keep
// their default values.
// -----------------------------------------------------------------------------
module tb_fsk_modulator;

    localparam int H0   = 100;
    localparam int H1   = 147;
    localparam int CPB  = 2;
    localparam int PRE  = 4;
    localparam int WAIT_LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       fsk_out;
    logic       busy;
    logic       sym_out;

    always #5 clk = ~clk;

    fsk_modulator #(
        .HALF0          (H0),
        .HALF1          (H1),
        .CYCLES_PER_BIT (CPB),
        .PREAMBLE_BITS  (PRE),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fsk_out  (fsk_out),
        .busy     (busy),
        .sym_out  (sym_out)
    );

    typedef struct {
        int len;
        int sym;
    } run_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    run_t       exp_runs[$];
    int         exp_len = 0;
    bit         mon_en = 1'b0;
    bit         aborting = 1'b0;
    bit         prev_busy = 1'b0;
    int         level = 0;
    int         run_len = 0;
    int         frame_cycles = 0;
    int         idle_cnt = 0;
    int         last_gap = 0;
    int         frames_done = 0;
    int         frames_expected = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: symbol list of the frame, each symbol = 2*CPB half-periods
    task automatic build_frame(input logic [7:0] b);
        int syms[$];
        int len;
        syms = {};
        for (int i = 0; i < PRE; i++) syms.push_back(1);
        syms.push_back(0);
        for (int i = 0; i < 8; i++) syms.push_back(int'(b[i]));
`ifdef FSK_PARITY_EN
        syms.push_back(int'(^b));
`endif
        syms.push_back(1);
        exp_runs.delete();
        exp_len = 0;
        foreach (syms[k]) begin
            len = (syms[k] != 0) ? H1 : H0;
            for (int h = 0; h < 2 * CPB; h++) begin
                exp_runs.push_back('{len: len, sym: syms[k]});
                exp_len += len;
            end
        end
    endtask

    task automatic end_run();
        if (exp_runs.size() == 0) begin
            check("extra_run", 1, 0);
        end else begin
            check("run_len", run_len, exp_runs[0].len);
            void'(exp_runs.pop_front());
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (!prev_busy) begin
                    last_gap = idle_cnt;
                    idle_cnt = 0;
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                        exp_runs.delete();
                    end else begin
                        build_frame(sb_q.pop_front());
                    end
                    check("start_high", int'(fsk_out), 1);
                    level = 1;
                    run_len = 1;
                    frame_cycles = 1;
                    if (exp_runs.size() > 0) check("sym_out", int'(sym_out), exp_runs[0].sym);
                end else begin
                    frame_cycles++;
                    if (int'(fsk_out) == level) begin
                        run_len++;
                    end else begin
                        end_run();
                        level = int'(fsk_out);
                        run_len = 1;
                        if (exp_runs.size() > 0) check("sym_out", int'(sym_out), exp_runs[0].sym);
                    end
                end
            end else begin
                if (prev_busy) begin
                    if (aborting) begin
                        check("abort_low", int'(fsk_out), 0);
                        exp_runs.delete();
                        aborting = 1'b0;
                    end else begin
                        end_run();
                        check("runs_left", exp_runs.size(), 0);
                        check("frame_len", frame_cycles, exp_len);
                        check("end_ready", int'(in_ready), 1);
                        frames_done++;
                    end
                end
                idle_cnt++;
                check("idle_low", int'(fsk_out), 0);
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // Offer a byte; in_data is scrambled while the block is not ready
    task automatic send(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < WAIT_LIMIT) begin
            in_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            in_data = b;
            sb_q.push_back(b);
            frames_expected++;
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 4 * WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bit         rh;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fsk", int'(fsk_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_sym", int'(sym_out), 0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);
        repeat (1000) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_ready", int'(in_ready), 1);

        // Single frame 0xA5
        send(8'hA5, 1'b0);
        wait_idle();

        // Back-to-back with valid held
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        @(negedge clk);
        check("b2b_gap", last_gap, 1);
        wait_idle();

        // Reset in the middle of the data bits
        send(8'h5A, 1'b0);
        repeat (3000) @(negedge clk);
        check("pre_abort_busy", int'(busy), 1);
        aborting = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_fsk", int'(fsk_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        frames_expected--;
        @(negedge clk);
        check("ready_after_abort", int'(in_ready), 1);
        send(8'h81, 1'b0);
        wait_idle();

        // Random bytes, random holding and gaps
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            rh = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(rb, rh);
        end
        wait_idle();
        wait_idle();
        wait_idle();

        check("frames_done", frames_done, frames_expected);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_modulator.md
Name: fsk_modulator

Overview:
- Byte-serial FSK transmitter; the transmit end of the link that fsk_demodulator receives.
- Accepts bytes on a valid/ready handshake and frames each one as: preamble, start bit, 8 data bits LSB first, stop bit.
- Each bit is sent as a square-wave carrier on fsk_out. Half-period length selects the symbol; carrier phase is continuous across bit boundaries.
- Line is held low and silent when idle, so the receiver's timeout resets its accumulator between frames.

Parameters:
- HALF0, 100, clocks per carrier half-period for symbol 0 (edge interval 99, two-interval sum 198 decodes as 0).
- HALF1, 147, clocks per carrier half-period for symbol 1 (edge interval 146, sum 292 falls inside the receiver's 1-window 284..300).
- CYCLES_PER_BIT, 8, full carrier cycles per bit.
- PREAMBLE_BITS, 4, symbol-1 bits sent before the start bit.
- CNT_W, 16, width of the half-period counter; must satisfy 2^CNT_W > max(HALF0,HALF1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- in_data  in  8  byte to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte
- fsk_out  out  1  FSK carrier output
- busy  out  1  frame in progress
- sym_out  out  1  symbol currently being sent (debug)

Behaviour:
- Reset: sampled on posedge clk while rst_n=0.
  - fsk_out=0, busy=0, in_ready=0, sym_out=0, state=IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately; the partial frame is not resumed.
  - in_ready rises on the first clock edge after rst_n=1.
- States: IDLE, PREAMBLE, START, DATA, [PARITY], STOP. All outputs are registered.
- IDLE:
  - in_ready=1, fsk_out=0, busy=0.
  - On the edge where in_valid&&in_ready: latch in_data into a shift register, set in_ready=0, busy=1, fsk_out=1, half_cnt=0, state=PREAMBLE, sym_out=1.
- Tone generation for the current symbol s:
  - half_cnt increments every clock.
  - When half_cnt==HALF_s-1: toggle fsk_out, clear half_cnt, increment half_idx.
  - Result: fsk_out is high exactly HALF_s clocks and low exactly HALF_s clocks.
- Bit end: at the toggle where half_idx reaches 2*CYCLES_PER_BIT-1.
  - The bit ends on a high-going toggle, so the next bit starts high.
  - The next symbol's HALF applies from the very next clock. sym_out updates on that same edge.
- Sequencing:
  - PREAMBLE: PREAMBLE_BITS symbol-1 bits.
  - START: one symbol-0 bit.
  - DATA: 8 bits, LSB first, shift register shifted right at each bit end.
  - STOP: one symbol-1 bit.
- End of STOP: instead of toggling high, fsk_out stays 0, busy=0, state=IDLE, in_ready=1 on that same edge.
- Back-to-back bytes:
  - A byte held valid is accepted on the edge after the return to IDLE.
  - Minimum inter-frame gap is one clock low.
  - Every frame repeats the preamble.
- Handshake:
  - in_valid is ignored while in_ready=0.
  - in_data is sampled only on the accept edge.
- Frame duration (no parity): 2*CYCLES_PER_BIT*(HALF1*(PREAMBLE_BITS+1+n1) + HALF0*(1+n0)) clocks, where n1/n0 are the counts of 1/0 data bits.
- half_idx width: ceil(log2(2*CYCLES_PER_BIT)). Bit counter: 4 bits.

Optional Feature:
- FSK_PARITY_EN defined: PARITY state between DATA and STOP sends one even-parity bit (XOR of the 8 data bits) for CYCLES_PER_BIT cycles.
- Undefined: DATA goes directly to STOP; no parity logic is generated.

Decomposition:
- Shared package fsk_pkg:
  - state enum;
  - default HALF0/HALF1/CYCLES_PER_BIT constants;
  - receiver threshold constants derived from them, so modulator and demodulator stay consistent.
- Sub-module fsk_tone_gen:
  - inputs: clk, rst_n, run, sym;
  - outputs: fsk_out, bit_done pulse;
  - contains half_cnt and half_idx.
- fsk_modulator keeps the FSM, shift register and handshake.

Test Plan:
- Reset then idle, in_valid=0 for 10000 clocks -> fsk_out=0, in_ready=1 from cycle 1 after release, busy=0.
- Send 0xA5 -> edge intervals 146 for preamble/1-bits and 99 for 0-bits; bit order after preamble is 0,1,0,1,0,0,1,0,1,1. Total duration = 16*(147*9 + 100*5) = 29168 clocks, then fsk_out=0 and in_ready=1.
- Loopback through fsk_demodulator, bytes 0x00, 0xFF, 0x3C -> demodulator data_out follows each transmitted symbol; no interval differs from 99/146.
- in_valid held with 0x11 then 0x22 -> second accept exactly one clock after the first STOP ends; in_data changes while busy are ignored.
- rst_n low for 1 clock mid-DATA of 0x5A -> next clock fsk_out=0, busy=0; after release, a new byte 0x81 transmits a full frame correctly.
- With FSK_PARITY_EN, send 0x07 -> parity bit =1 (146-clock intervals) between data and stop; frame is 16*HALF1 clocks longer than without parity.
